// File: rtl/id_ex_latch.sv
// id_ex_latch
//   ID/EX pipeline register. Captures the decoded instruction bundle and
//   presents it, registered, to the execute stage. Supports stall (hold),
//   flush (bubble insertion) and a halt tracker: once a valid HALT is loaded
//   into EX, every later unstalled edge loads a bubble until a flush or reset.
//
//   Optional feature macro: ID_EX_BUBBLE_CNT_EN
//     When defined, adds output bubble_cnt, a saturating count of unstalled
//     edges that loaded a bubble. When undefined, neither the port nor the
//     counter exists.
//
//   Ports
//     clk, rst          core clock, synchronous active-high reset
//     id_valid          decode slot holds a real instruction
//     id_opcode/func    opcode [15:11], R-format function bits [1:0]
//     id_rs_data/rt_data, id_imm, id_pc_inc   datapath values (DW bits)
//     id_wr_reg         destination register (RW bits)
//     id_ctrl           {reg_write, mem_read, mem_write, mem_to_reg}
//     stall, flush      hold contents / replace contents with a bubble
//     ex_*              registered copies of the id_* bundle
//     halted            tracker is in HALTED
//     bubble_cnt        (macro only) saturating bubble counter
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | normal issue: valid id_ bundles are loaded into EX
//   ST_HALT | a HALT reached EX; id_ inputs ignored, bubbles loaded

module id_ex_latch #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [4:0]    id_opcode,
    input  logic [1:0]    id_func,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc_inc,
    input  logic [RW-1:0] id_wr_reg,
    input  logic [3:0]    id_ctrl,
    input  logic          stall,
    input  logic          flush,
    output logic          ex_valid,
    output logic [4:0]    ex_opcode,
    output logic [1:0]    ex_func,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc_inc,
    output logic [RW-1:0] ex_wr_reg,
    output logic [3:0]    ex_ctrl,
    output logic          halted
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [DW-1:0] bubble_cnt
`endif
);

    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_HALT = 5'b00000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state;

    logic load_id;
    logic load_bubble;

    // Flush beats stall; with neither, RUN loads a valid bundle and every
    // other case (invalid slot, HALTED) loads a bubble.
    always_comb begin
        load_id     = 1'b0;
        load_bubble = 1'b0;
        if (flush) begin
            load_bubble = 1'b1;
        end else if (!stall) begin
            if (state == ST_RUN && id_valid) begin
                load_id = 1'b1;
            end else begin
                load_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            ex_valid   <= 1'b0;
            ex_opcode  <= OP_NOP;
            ex_func    <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc_inc  <= '0;
            ex_wr_reg  <= '0;
            ex_ctrl    <= 4'b0000;
        end else if (load_id) begin
            ex_valid   <= 1'b1;
            ex_opcode  <= id_opcode;
            ex_func    <= id_func;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc_inc  <= id_pc_inc;
            ex_wr_reg  <= id_wr_reg;
            ex_ctrl    <= id_ctrl;
        end
    end

    // A flush cancels a wrong-path HALT; otherwise HALTED is sticky.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= ST_RUN;
        end else if (load_id && id_opcode == OP_HALT) begin
            state <= ST_HALT;
        end
    end

    assign halted = (state == ST_HALT);

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (load_bubble && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + DW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch
//   Self-checking bench for id_ex_latch: a directed vector table walking the
//   load / stall / flush / halt scenarios, followed by randomized traffic.
//   A reference model of the pipeline register runs in parallel with every
//   cycle and checks the full EX bundle and the halted flag.

module tb_id_ex_latch;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_opcode;
    logic [1:0]    id_func;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc_inc;
    logic [RW-1:0] id_wr_reg;
    logic [3:0]    id_ctrl;
    logic          stall, flush;
    logic          ex_valid;
    logic [4:0]    ex_opcode;
    logic [1:0]    ex_func;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_inc;
    logic [RW-1:0] ex_wr_reg;
    logic [3:0]    ex_ctrl;
    logic          halted;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [DW-1:0] bubble_cnt;
`endif

    id_ex_latch #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_func(id_func),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_pc_inc(id_pc_inc), .id_wr_reg(id_wr_reg), .id_ctrl(id_ctrl),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func(ex_func),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_pc_inc(ex_pc_inc), .ex_wr_reg(ex_wr_reg), .ex_ctrl(ex_ctrl),
        .halted(halted)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [4:0]    opcode;
        logic [1:0]    func;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [RW-1:0] wr;
        logic [3:0]    ctrl;
    } bundle_t;

    localparam bundle_t BUBBLE = '{valid: 1'b0, opcode: 5'b00001, default: '0};

    bundle_t dut_b;
    assign dut_b = {ex_valid, ex_opcode, ex_func, ex_rs_data, ex_rt_data,
                    ex_imm, ex_pc_inc, ex_wr_reg, ex_ctrl};

    int checks   = 0;
    int failures = 0;

    // Reference model state: what EX should hold and whether issue is frozen.
    bundle_t       m_b;
    bit            m_halted;
    int unsigned   m_cnt;

    // Applies one clock edge to the model, using the inputs as driven now.
    task automatic model_edge();
        bundle_t in_b;
        bit      take_bubble;
        in_b = {1'b1, id_opcode, id_func, id_rs_data, id_rt_data,
                id_imm, id_pc_inc, id_wr_reg, id_ctrl};
        take_bubble = 1'b0;
        if (rst) begin
            m_b = BUBBLE; m_halted = 1'b0; m_cnt = 0;
        end else if (flush) begin
            m_b = BUBBLE; m_halted = 1'b0; take_bubble = 1'b1;
        end else if (stall) begin
            // everything holds
        end else if (m_halted || !id_valid) begin
            m_b = BUBBLE; take_bubble = 1'b1;
        end else begin
            m_b = in_b;
            if (id_opcode == 5'd0) m_halted = 1'b1;
        end
        if (take_bubble && m_cnt < 65535) m_cnt = m_cnt + 1;
    endtask

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge, then compare the DUT against the model.
    task automatic step(string tag);
        @(posedge clk);
        #1;
        model_edge();
        check({tag, "_model_bundle"}, 128'(dut_b), 128'(m_b));
        check({tag, "_model_halted"}, 128'(halted), 128'(m_halted));
`ifdef ID_EX_BUBBLE_CNT_EN
        check({tag, "_model_cnt"}, 128'(bubble_cnt), 128'(m_cnt));
`endif
    endtask

    typedef struct {
        bit        rst, flush, stall, valid;
        bit [4:0]  op;
        bit [15:0] rs, imm;
        bit [3:0]  ctrl;
        bit        e_valid;
        bit [4:0]  e_op;
        bit [15:0] e_rs, e_imm;
        bit [3:0]  e_ctrl;
        bit        e_halted;
    } vec_t;

    function automatic vec_t mk(bit r, bit f, bit s, bit v, bit [4:0] op,
                                bit [15:0] rs, bit [15:0] imm, bit [3:0] ctrl,
                                bit ev, bit [4:0] eop, bit [15:0] ers,
                                bit [15:0] eimm, bit [3:0] ectrl, bit eh);
        vec_t x;
        x.rst = r; x.flush = f; x.stall = s; x.valid = v; x.op = op;
        x.rs = rs; x.imm = imm; x.ctrl = ctrl;
        x.e_valid = ev; x.e_op = eop; x.e_rs = ers; x.e_imm = eimm;
        x.e_ctrl = ectrl; x.e_halted = eh;
        return x;
    endfunction

    vec_t vt[20];

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
        id_opcode = '0; id_func = '0; id_rs_data = '0; id_rt_data = '0;
        id_imm = '0; id_pc_inc = '0; id_wr_reg = '0; id_ctrl = '0;
        m_b = BUBBLE; m_halted = 1'b0; m_cnt = 0;

        //          rst f s  v op     rs        imm       ctrl  | ev eop   ers       eimm      ectrl eh
        vt[0]  = mk(1,0,0, 1,5'h08, 16'h0005, 16'h0003, 4'h8,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 0);
        vt[1]  = mk(0,0,0, 1,5'h08, 16'h0005, 16'h0003, 4'h8,  1,5'h08, 16'h0005, 16'h0003, 4'h8, 0);
        vt[2]  = mk(0,0,1, 1,5'h09, 16'h0007, 16'h0009, 4'hC,  1,5'h08, 16'h0005, 16'h0003, 4'h8, 0);
        vt[3]  = mk(0,0,1, 1,5'h11, 16'h0077, 16'h0099, 4'hA,  1,5'h08, 16'h0005, 16'h0003, 4'h8, 0);
        vt[4]  = mk(0,0,1, 0,5'h00, 16'h0123, 16'h0456, 4'hF,  1,5'h08, 16'h0005, 16'h0003, 4'h8, 0);
        vt[5]  = mk(0,0,0, 1,5'h09, 16'h0007, 16'h0009, 4'h8,  1,5'h09, 16'h0007, 16'h0009, 4'h8, 0);
        vt[6]  = mk(0,1,1, 1,5'h11, 16'h0040, 16'h0004, 4'hC,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 0);
        vt[7]  = mk(0,0,0, 1,5'h00, 16'h0000, 16'h0000, 4'h0,  1,5'h00, 16'h0000, 16'h0000, 4'h0, 1);
        vt[8]  = mk(0,0,0, 1,5'h1B, 16'hAAAA, 16'h0000, 4'h8,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 1);
        vt[9]  = mk(0,0,0, 1,5'h1B, 16'hBBBB, 16'h0001, 4'h8,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 1);
        vt[10] = mk(0,0,1, 1,5'h1B, 16'hCCCC, 16'h0002, 4'h8,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 1);
        vt[11] = mk(0,1,0, 1,5'h1B, 16'hDDDD, 16'h0003, 4'h8,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 0);
        vt[12] = mk(0,0,0, 1,5'h09, 16'h1234, 16'h0022, 4'h8,  1,5'h09, 16'h1234, 16'h0022, 4'h8, 0);
        vt[13] = mk(0,0,0, 0,5'h08, 16'h5555, 16'h6666, 4'hF,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 0);
        vt[14] = mk(0,0,0, 1,5'h00, 16'h0001, 16'h0002, 4'h0,  1,5'h00, 16'h0001, 16'h0002, 4'h0, 1);
        vt[15] = mk(0,0,1, 1,5'h08, 16'h0009, 16'h0009, 4'h8,  1,5'h00, 16'h0001, 16'h0002, 4'h0, 1);
        vt[16] = mk(0,0,1, 1,5'h08, 16'h0009, 16'h0009, 4'h8,  1,5'h00, 16'h0001, 16'h0002, 4'h0, 1);
        vt[17] = mk(1,0,1, 1,5'h08, 16'h0009, 16'h0009, 4'h8,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 0);
        vt[18] = mk(0,0,1, 1,5'h08, 16'h0009, 16'h0009, 4'h8,  0,5'h01, 16'h0000, 16'h0000, 4'h0, 0);
        vt[19] = mk(0,0,0, 1,5'h08, 16'h0009, 16'h0009, 4'h8,  1,5'h08, 16'h0009, 16'h0009, 4'h8, 0);

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            rst = vt[i].rst; flush = vt[i].flush; stall = vt[i].stall;
            id_valid = vt[i].valid; id_opcode = vt[i].op;
            id_rs_data = vt[i].rs; id_imm = vt[i].imm; id_ctrl = vt[i].ctrl;
            id_func = 2'(i); id_rt_data = 16'h0100 + 16'(i);
            id_pc_inc = 16'h0200 + 16'(2 * i); id_wr_reg = 3'(i);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d_fields", i),
                  128'({ex_valid, ex_opcode, ex_rs_data, ex_imm, ex_ctrl}),
                  128'({vt[i].e_valid, vt[i].e_op, vt[i].e_rs, vt[i].e_imm, vt[i].e_ctrl}));
            check($sformatf("vec%0d_halted", i), 128'(halted), 128'(vt[i].e_halted));
        end

        // Randomized traffic; HALT opcodes are made common so the halted
        // path is exercised often.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_opcode  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            id_func    = 2'($urandom);
            id_rs_data = 16'($urandom);
            id_rt_data = 16'($urandom);
            id_imm     = 16'($urandom);
            id_pc_inc  = 16'($urandom);
            id_wr_reg  = 3'($urandom);
            id_ctrl    = 4'($urandom);
            step("rand");
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        // 2 flushes + 1 invalid slot count; 2 stalled invalid slots do not.
        rst = 1'b1; flush = 1'b0; stall = 1'b0; id_valid = 1'b1; id_opcode = 5'h08;
        step("cnt_rst");
        rst = 1'b0; flush = 1'b1; step("cnt_f1");
        step("cnt_f2");
        flush = 1'b0; id_valid = 1'b0; step("cnt_inv");
        stall = 1'b1; step("cnt_s1");
        step("cnt_s2");
        check("cnt_after_seq", 128'(bubble_cnt), 128'(3));
        stall = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            #1;
            model_edge();
        end
        check("cnt_saturate", 128'(bubble_cnt), 128'(16'hFFFF));
        step("cnt_hold_sat");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
